div_unit_p: RTL

DIV_UNIT_P -- requirements
Module: div_unit_p

---
 rtl/div_unit_p.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/div_unit_p.sv
// div_unit_p: memory-mapped W/W and 2W/W integer divider using restoring iteration.
// Define DIV_UNIT_P_UNSIGNED_EN to make DVCR.UNS writable (unsigned mode); otherwise all divisions are signed.
module div_unit_p #(
    parameter int unsigned W          = 32,
    parameter int unsigned RADIX_BITS = 1,
    parameter logic [31:0] BASE       = 32'hFFFFFF00
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic [31:0] IBUS_DO,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    output logic        IRQ,
    output logic [7:0]  VEC
);
    localparam int unsigned N     = W / RADIX_BITS;
    localparam int unsigned CNT_W = $clog2(N + 1);
`ifdef DIV_UNIT_P_UNSIGNED_EN
    localparam logic UNS_EN = 1'b1;
`else
    localparam logic UNS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_WB} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_dvsr;
    logic [W-1:0]       r_dvdnth;
    logic [W-1:0]       r_dvdntl;
    logic               r_ovf;
    logic               r_ovfie;
    logic               r_uns;
    logic [7:0]         r_vcr;
    logic               r_busy;
    logic [31:0]        r_rdata;
    logic [W-1:0]       r_rem;
    logic [W-1:0]       r_quo;
    logic [W-1:0]       r_div;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_dovf;
    logic [CNT_W-1:0]   r_cnt;

    logic [31:0]        w_off;
    logic               w_act;
    logic [2:0]         w_reg;
    logic               w_operate;
    logic               w_wr;
    logic               w_lo_en;
    logic               w_start;
    logic [W-1:0]       w_di;
    logic [31:0]        w_rd;
    logic [2*W-1:0]     w_dvdnt;
    logic [2*W-1:0]     w_dvdnt_mag;
    logic [W-1:0]       w_dvsr_mag;
    logic               w_dvdnt_neg;
    logic               w_dvsr_neg;
    logic               w_dvsr_zero;
    logic               w_load_ovf;
    logic               w_fix_ovf;
    logic [W-1:0]       w_sat;
    logic [W:0]         w_t;
    logic [W-1:0]       w_rem_nxt;
    logic [W-1:0]       w_quo_nxt;
    logic               w_unused;

    // Address window decode
    assign w_off     = IBUS_A - BASE;
    assign w_act     = (IBUS_A >= BASE) && (w_off < 32'd32);
    assign w_reg     = w_off[4:2];
    assign w_operate = (r_state != S_IDLE);
    assign w_wr      = CE_R && RES_N && IBUS_REQ && IBUS_WE && w_act && !w_operate;
    assign w_lo_en   = IBUS_BA[0] | IBUS_BA[1];
    assign w_start   = w_wr && ((w_reg == 3'd1) || (w_reg == 3'd5));
    assign w_di      = W'(IBUS_DI);
    assign w_unused  = &{1'b0, IBUS_BA[3:2]};

    // Operand magnitudes and early overflow, consumed in LOAD
    assign w_dvdnt     = {r_dvdnth, r_dvdntl};
    assign w_dvdnt_neg = !r_uns && r_dvdnth[W-1];
    assign w_dvsr_neg  = !r_uns && r_dvsr[W-1];
    assign w_dvdnt_mag = w_dvdnt_neg ? -w_dvdnt : w_dvdnt;
    assign w_dvsr_mag  = w_dvsr_neg ? -r_dvsr : r_dvsr;
    assign w_dvsr_zero = (r_dvsr == '0);
    assign w_load_ovf  = w_dvsr_zero || (w_dvdnt_mag[2*W-1:W] >= w_dvsr_mag);

    // Signed quotient magnitude must fit the signed W-bit range
    assign w_fix_ovf = !r_uns && (r_qneg ? (r_quo > {1'b1, {(W-1){1'b0}}}) : r_quo[W-1]);
    assign w_sat     = r_uns ? '1 : (r_qneg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

    // RADIX_BITS restoring steps per iteration cycle
    always_comb begin
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        w_t       = '0;
        for (int i = 0; i < int'(RADIX_BITS); i++) begin
            w_t = {w_rem_nxt, w_quo_nxt[W-1]};
            if (w_t >= {1'b0, r_div}) begin
                w_t       = w_t - {1'b0, r_div};
                w_quo_nxt = {w_quo_nxt[W-2:0], 1'b1};
            end else begin
                w_quo_nxt = {w_quo_nxt[W-2:0], 1'b0};
            end
            w_rem_nxt = w_t[W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_state <= S_IDLE;
        else if (CE_R)
            r_state <= RES_N ? w_state_nxt : S_IDLE;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_dvsr_zero ? S_WB : S_ITER;
            S_ITER:  if (r_cnt == CNT_W'(N - 1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Register file, CPU writes and sequencer datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dvsr <= '0; r_dvdnth <= '0; r_dvdntl <= '0;
            r_ovf <= 1'b0; r_ovfie <= 1'b0; r_uns <= 1'b0; r_vcr <= '0;
            r_rem <= '0; r_quo <= '0; r_div <= '0;
            r_qneg <= 1'b0; r_rneg <= 1'b0; r_dovf <= 1'b0; r_cnt <= '0;
        end else if (CE_R) begin
            if (!RES_N) begin
                r_dvsr <= '0; r_dvdnth <= '0; r_dvdntl <= '0;
                r_ovf <= 1'b0; r_ovfie <= 1'b0; r_uns <= 1'b0; r_vcr <= '0;
                r_rem <= '0; r_quo <= '0; r_div <= '0;
                r_qneg <= 1'b0; r_rneg <= 1'b0; r_dovf <= 1'b0; r_cnt <= '0;
            end else begin
                if (w_wr) begin
                    case (w_reg)
                        3'd0: r_dvsr <= w_di;
                        3'd1: begin
                            r_dvdntl <= w_di;
                            r_dvdnth <= {W{!r_uns && w_di[W-1]}};
                        end
                        3'd2: if (w_lo_en) begin
                            r_ovf   <= r_ovf & IBUS_DI[0];
                            r_ovfie <= IBUS_DI[1];
                            r_uns   <= UNS_EN & IBUS_DI[2];
                        end
                        3'd3: if (w_lo_en) r_vcr <= IBUS_DI[7:0];
                        3'd4: r_dvdnth <= w_di;
                        3'd5: r_dvdntl <= w_di;
                        default: ;
                    endcase
                end
                case (r_state)
                    S_LOAD: begin
                        r_rem  <= w_dvdnt_mag[2*W-1:W];
                        r_quo  <= w_dvdnt_mag[W-1:0];
                        r_div  <= w_dvsr_mag;
                        r_qneg <= w_dvdnt_neg ^ w_dvsr_neg;
                        r_rneg <= w_dvdnt_neg;
                        r_dovf <= w_load_ovf;
                        r_cnt  <= '0;
                    end
                    S_ITER: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    S_FIX: begin
                        r_quo  <= r_qneg ? -r_quo : r_quo;
                        r_rem  <= r_rneg ? -r_rem : r_rem;
                        r_dovf <= r_dovf | w_fix_ovf;
                    end
                    S_WB: begin
                        if (r_dovf) begin
                            r_ovf <= 1'b1;
                            if (!r_ovfie) r_dvdntl <= w_sat;
                        end else begin
                            r_dvdntl <= r_quo;
                            r_dvdnth <= r_rem;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_reg)
            3'd0:       w_rd = 32'(r_dvsr);
            3'd1:       w_rd = 32'(r_dvdntl);
            3'd2:       w_rd = {29'd0, r_uns, r_ovfie, r_ovf};
            3'd3:       w_rd = {24'd0, r_vcr};
            3'd4, 3'd6: w_rd = 32'(r_dvdnth);
            default:    w_rd = 32'(r_dvdntl);
        endcase
    end

    // Read data captured on CE_F; frozen while a division is in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_rdata <= '0;
        else if (CE_R && !RES_N)
            r_rdata <= '0;
        else if (CE_F && !w_operate && w_act && IBUS_REQ && !IBUS_WE)
            r_rdata <= w_rd;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_busy <= 1'b0;
        else if (CE_R) begin
            if (!RES_N)
                r_busy <= 1'b0;
            else if (IBUS_REQ && w_act)
                r_busy <= w_operate;
        end
    end

    assign IBUS_DO   = w_act ? r_rdata : 32'd0;
    assign IBUS_BUSY = r_busy;
    assign IBUS_ACT  = w_act;
    assign IRQ       = r_ovf & r_ovfie;
    assign VEC       = r_vcr;

endmodule
